// File: rtl/rk_spi_pkg.sv
// Shared SPI framing types and the register map seen by the 40 MHz decoder.
package rk_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } spi_state_t;

   localparam int SPI_READ_BIT = 7;

   localparam logic [7:0] REG_ID        = 8'h00;
   localparam logic [7:0] REG_CTRL      = 8'h04;
   localparam logic [7:0] REG_STATUS    = 8'h05;
   localparam logic [7:0] REG_SCRATCH   = 8'h06;
   localparam logic [7:0] REG_DAC       = 8'h20;
   localparam logic [7:0] REG_RD_FIFO0  = 8'h80;
   localparam logic [7:0] REG_RD_FIFO1  = 8'h81;
   localparam logic [7:0] REG_RD_FIFO2  = 8'h82;
   localparam logic [7:0] REG_RD_FIFO3  = 8'h83;
   localparam logic [7:0] REG_RD_VER    = 8'h88;
   localparam logic [7:0] REG_RD_STAT0  = 8'h90;
   localparam logic [7:0] REG_RD_STAT1  = 8'h91;
   localparam logic [7:0] REG_RD_DBG    = 8'hA0;

   function automatic logic is_read(input logic [7:0] a);
      return a[SPI_READ_BIT];
   endfunction

endpackage

// File: rtl/spi_frame_engine_if.sv
// Pin-side inputs and decoder-facing outputs of the SPI framing stage.
interface spi_frame_engine_if #(
   parameter int BYTE_CNT_W = 8,
   parameter int RUNT_CNT_W = 8
);
   logic                  spi_start;
   logic                  spi_mosi;
   logic [7:0]            tx_data;
   logic [7:0]            addr_peek;
   logic [7:0]            addr;
   logic                  addr_toggle;
   logic [7:0]            rx_byte;
   logic [BYTE_CNT_W-1:0] rx_idx;
   logic                  rx_toggle;
   logic                  rd_toggle;
   logic                  miso_bit;
   logic [RUNT_CNT_W-1:0] runt_cnt;
   logic                  frame_err;

   modport master (
      output spi_start, spi_mosi, tx_data,
      input  addr_peek, addr, addr_toggle, rx_byte, rx_idx, rx_toggle,
             rd_toggle, miso_bit, runt_cnt, frame_err
   );

   modport slave (
      input  spi_start, spi_mosi, tx_data,
      output addr_peek, addr, addr_toggle, rx_byte, rx_idx, rx_toggle,
             rd_toggle, miso_bit, runt_cnt, frame_err
   );
endinterface

// File: rtl/spi_shift8.sv
// 8-bit MSB-first shift register with parallel load and a 3-bit bit counter.
// Load wins over shift; the counter wraps 7 -> 0 on its own.
module spi_shift8 (
   input  logic       spi_clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_dat,
   input  logic [2:0] load_cnt,
   input  logic       shift,
   input  logic       shift_in,
   output logic [7:0] q,
   output logic [2:0] cnt
);

   always_ff @(posedge spi_clk) begin
      if (reset) begin
         q   <= '0;
         cnt <= '0;
      end else if (load) begin
         q   <= load_dat;
         cnt <= load_cnt;
      end else if (shift) begin
         q   <= {q[6:0], shift_in};
         cnt <= cnt + 3'd1;
      end
   end

endmodule

// File: rtl/spi_frame_engine.sv
// Frames the MOSI stream into address/data bytes, serialises readback onto MISO.
// Byte results register on the edge of their last bit; announced by level toggles.
module spi_frame_engine
   import rk_spi_pkg::*;
#(
   parameter int BYTE_CNT_W = 8,
   parameter int RUNT_CNT_W = 8
) (
   input logic               spi_clk,
   input logic               reset,
   spi_frame_engine_if.slave bus
);

   spi_state_t            state, state_nxt;
   logic [7:0]            sr, tx_q;
   logic [2:0]            bit_cnt, tx_cnt;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   logic                  rx_load, rx_shift, tx_load, tx_shift;
   logic                  addr_done, data_done, runt;
   logic                  unused_bits;

   assign bus.addr_peek = {sr[6:0], bus.spi_mosi};
   assign unused_bits   = ^{sr[7], tx_q[7], tx_q[5:0], tx_cnt};

   spi_shift8 u_rx (
      .spi_clk  (spi_clk),
      .reset    (reset),
      .load     (rx_load),
      .load_dat ({7'b0, bus.spi_mosi}),
      .load_cnt (3'd1),
      .shift    (rx_shift),
      .shift_in (bus.spi_mosi),
      .q        (sr),
      .cnt      (bit_cnt)
   );

   spi_shift8 u_tx (
      .spi_clk  (spi_clk),
      .reset    (reset),
      .load     (tx_load),
      .load_dat (bus.tx_data),
      .load_cnt (3'd0),
      .shift    (tx_shift),
      .shift_in (1'b0),
      .q        (tx_q),
      .cnt      (tx_cnt)
   );

   always_ff @(posedge spi_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rx_load   = 1'b0;
      rx_shift  = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      addr_done = 1'b0;
      data_done = 1'b0;
      runt      = 1'b0;
      if (bus.spi_start) begin
         state_nxt = ADDR;
         rx_load   = 1'b1;
         // A new frame is clean only on a byte boundary of the data phase.
         runt      = (state == ADDR) || (state == DATA && bit_cnt != 3'd0);
      end else begin
         case (state)
            ADDR: begin
               rx_shift = 1'b1;
               if (bit_cnt == 3'd7) begin
                  addr_done = 1'b1;
                  tx_load   = 1'b1;
                  state_nxt = DATA;
               end
            end
            DATA: begin
               rx_shift = 1'b1;
               if (bit_cnt == 3'd7) begin
                  data_done = 1'b1;
                  tx_load   = 1'b1;
               end else begin
                  tx_shift  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge spi_clk) begin
      if (reset) begin
         bus.addr        <= '0;
         bus.addr_toggle <= 1'b0;
         bus.rx_byte     <= '0;
         bus.rx_idx      <= '0;
         bus.rx_toggle   <= 1'b0;
         bus.rd_toggle   <= 1'b0;
         bus.miso_bit    <= 1'b0;
         bus.runt_cnt    <= '0;
         bus.frame_err   <= 1'b0;
         byte_cnt        <= '0;
      end else begin
         if (bus.spi_start) byte_cnt <= '0;
         if (runt) begin
            bus.frame_err <= 1'b1;
            if (bus.runt_cnt != {RUNT_CNT_W{1'b1}})
               bus.runt_cnt <= bus.runt_cnt + RUNT_CNT_W'(1);
         end
         if (addr_done) begin
            bus.addr        <= bus.addr_peek;
            bus.addr_toggle <= ~bus.addr_toggle;
            if (is_read(bus.addr_peek)) bus.rd_toggle <= ~bus.rd_toggle;
         end
         if (data_done) begin
            bus.rx_byte   <= bus.addr_peek;
            bus.rx_idx    <= byte_cnt;
            bus.rx_toggle <= ~bus.rx_toggle;
            if (byte_cnt != {BYTE_CNT_W{1'b1}}) byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (is_read(bus.addr)) bus.rd_toggle <= ~bus.rd_toggle;
         end
         if (tx_load)       bus.miso_bit <= bus.tx_data[7];
         else if (tx_shift) bus.miso_bit <= tx_q[6];
      end
   end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Bench for spi_frame_engine: bit-level frame model checked every cycle plus directed literals.
module tb_spi_frame_engine;
   localparam int BW       = 8;
   localparam int RW       = 8;
   localparam int IDX_MAX  = (1 << BW) - 1;
   localparam int RUNT_MAX = (1 << RW) - 1;

   logic spi_clk = 1'b0;
   logic reset   = 1'b1;

   spi_frame_engine_if #(.BYTE_CNT_W(BW), .RUNT_CNT_W(RW)) bus ();

   spi_frame_engine #(.BYTE_CNT_W(BW), .RUNT_CNT_W(RW)) dut (
      .spi_clk (spi_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 spi_clk = ~spi_clk;

   int   n_pass = 0;
   int   n_chk  = 0;
   bit   chk_en = 1'b0;
   logic miso_log[$];

   // Model: frame position counted in bits since the start pulse.
   bit         m_in_frame = 1'b0;
   int         m_nbits    = 0;
   logic [7:0] m_sr       = '0;
   logic [7:0] m_addr     = '0;
   logic       m_addr_tg  = 1'b0;
   logic [7:0] m_rx_byte  = '0;
   int         m_idx      = 0;
   logic       m_rx_tg    = 1'b0;
   logic       m_rd_tg    = 1'b0;
   logic       m_miso     = 1'b0;
   int         m_runt     = 0;
   logic       m_err      = 1'b0;
   logic [7:0] m_txb      = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_step();
      if (reset) begin
         m_in_frame = 1'b0; m_nbits = 0; m_sr = '0; m_addr = '0; m_addr_tg = 1'b0;
         m_rx_byte = '0; m_idx = 0; m_rx_tg = 1'b0; m_rd_tg = 1'b0; m_miso = 1'b0;
         m_runt = 0; m_err = 1'b0; m_txb = '0;
      end else if (bus.spi_start) begin
         if (m_in_frame && (m_nbits % 8) != 0) begin
            m_runt = (m_runt < RUNT_MAX) ? m_runt + 1 : RUNT_MAX;
            m_err  = 1'b1;
         end
         m_in_frame = 1'b1;
         m_nbits    = 1;
         m_sr       = {7'b0, bus.spi_mosi};
      end else if (m_in_frame) begin
         m_sr    = {m_sr[6:0], bus.spi_mosi};
         m_nbits = m_nbits + 1;
         if ((m_nbits % 8) == 0) begin
            m_txb = bus.tx_data;
            if (m_nbits == 8) begin
               m_addr    = m_sr;
               m_addr_tg = ~m_addr_tg;
               if (m_sr[7]) m_rd_tg = ~m_rd_tg;
            end else begin
               m_rx_byte = m_sr;
               m_idx     = (m_nbits / 8 - 2 < IDX_MAX) ? m_nbits / 8 - 2 : IDX_MAX;
               m_rx_tg   = ~m_rx_tg;
               if (m_addr[7]) m_rd_tg = ~m_rd_tg;
            end
         end
         if (m_nbits >= 8) m_miso = m_txb[7 - (m_nbits % 8)];
      end
   endtask

   initial begin
      forever begin
         @(negedge spi_clk);
         model_step();
         if (chk_en) begin
            chk("addr_peek",   32'(bus.addr_peek),   32'({m_sr[6:0], bus.spi_mosi}));
            chk("addr",        32'(bus.addr),        32'(m_addr));
            chk("addr_toggle", 32'(bus.addr_toggle), 32'(m_addr_tg));
            chk("rx_byte",     32'(bus.rx_byte),     32'(m_rx_byte));
            chk("rx_idx",      32'(bus.rx_idx),      m_idx);
            chk("rx_toggle",   32'(bus.rx_toggle),   32'(m_rx_tg));
            chk("rd_toggle",   32'(bus.rd_toggle),   32'(m_rd_tg));
            chk("miso_bit",    32'(bus.miso_bit),    32'(m_miso));
            chk("runt_cnt",    32'(bus.runt_cnt),    m_runt);
            chk("frame_err",   32'(bus.frame_err),   32'(m_err));
         end
      end
   end

   task automatic send(input logic rst, input logic st, input logic m, input logic [7:0] td);
      @(negedge spi_clk);
      #1;
      reset         = rst;
      bus.spi_start = st;
      bus.spi_mosi  = m;
      bus.tx_data   = td;
      @(posedge spi_clk);
      #1;
      miso_log.push_back(bus.miso_bit);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic st, input logic [7:0] td);
      for (int i = 7; i >= 0; i--) send(1'b0, st && (i == 7), b[i], td);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"},   32'(bus.addr),        'h0);
      chk({tag, "_atg"},    32'(bus.addr_toggle), 'h0);
      chk({tag, "_rxbyte"}, 32'(bus.rx_byte),     'h0);
      chk({tag, "_rxidx"},  32'(bus.rx_idx),      'h0);
      chk({tag, "_rxtg"},   32'(bus.rx_toggle),   'h0);
      chk({tag, "_rdtg"},   32'(bus.rd_toggle),   'h0);
      chk({tag, "_miso"},   32'(bus.miso_bit),    'h0);
      chk({tag, "_runt"},   32'(bus.runt_cnt),    'h0);
      chk({tag, "_err"},    32'(bus.frame_err),   'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [7:0] got;
      logic [7:0] b;
      logic       tg_prev;
      int         flips;
      int         nb;

      bus.spi_start = 1'b0;
      bus.spi_mosi  = 1'b0;
      bus.tx_data   = 8'h00;
      reset         = 1'b1;
      repeat (2) @(posedge spi_clk);
      #1;
      chk_zero("reset");
      chk("reset_peek", 32'(bus.addr_peek), 'h0);
      chk_en = 1'b1;

      // Write frame 0x05, 0xA5
      send_byte(8'h05, 1'b1, 8'h00);
      chk("w05_addr", 32'(bus.addr), 'h05);
      chk("w05_atg",  32'(bus.addr_toggle), 'h1);
      send_byte(8'hA5, 1'b0, 8'h00);
      chk("w05_rxbyte", 32'(bus.rx_byte), 'hA5);
      chk("w05_rxidx",  32'(bus.rx_idx), 'h0);
      chk("w05_rxtg",   32'(bus.rx_toggle), 'h1);
      chk("w05_rdtg",   32'(bus.rd_toggle), 'h0);

      // Reset in the middle of a burst, then a clean frame
      send_byte(8'h06, 1'b1, 8'h00);
      send_byte(8'h11, 1'b0, 8'h00);
      send_byte(8'h22, 1'b0, 8'h00);
      repeat (3) send(1'b0, 1'b0, 1'b1, 8'h00);
      send(1'b1, 1'b0, 1'b0, 8'h00);
      chk_zero("midrst");
      repeat (2) send(1'b0, 1'b0, 1'b1, 8'h00);
      send_byte(8'h06, 1'b1, 8'h00);
      send_byte(8'h12, 1'b0, 8'h00);
      chk("w06_addr",   32'(bus.addr), 'h06);
      chk("w06_atg",    32'(bus.addr_toggle), 'h1);
      chk("w06_rxbyte", 32'(bus.rx_byte), 'h12);
      chk("w06_rxtg",   32'(bus.rx_toggle), 'h1);
      chk("w06_err",    32'(bus.frame_err), 'h0);

      // Read frame 0x88 with readback 0x3C then 0xC3
      miso_log.delete();
      send_byte(8'h88, 1'b1, 8'h3C);
      chk("r88_rdtg_e8", 32'(bus.rd_toggle), 'h1);
      send_byte(8'h5A, 1'b0, 8'hC3);
      chk("r88_rdtg_e16", 32'(bus.rd_toggle), 'h0);
      send_byte(8'h00, 1'b0, 8'h00);
      got = '0;
      for (int i = 0; i < 8; i++) got = {got[6:0], miso_log[7 + i]};
      chk("r88_miso_9_16", 32'(got), 'h3C);
      got = '0;
      for (int i = 0; i < 8; i++) got = {got[6:0], miso_log[15 + i]};
      chk("r88_miso_17_24", 32'(got), 'hC3);

      // Runt after 5 bits, then frame 0x20, 0x55
      send(1'b0, 1'b1, 1'b1, 8'h00);
      repeat (4) send(1'b0, 1'b0, 1'b1, 8'h00);
      send_byte(8'h20, 1'b1, 8'h00);
      chk("runt_cnt1", 32'(bus.runt_cnt), 'h1);
      chk("runt_err",  32'(bus.frame_err), 'h1);
      chk("runt_rxtg", 32'(bus.rx_toggle), 'h1);
      chk("runt_addr", 32'(bus.addr), 'h20);
      send_byte(8'h55, 1'b0, 8'h00);
      chk("runt_rxbyte", 32'(bus.rx_byte), 'h55);
      chk("runt_rxidx",  32'(bus.rx_idx), 'h0);

      // 300-byte burst to 0x06
      send_byte(8'h06, 1'b1, 8'h00);
      tg_prev = bus.rx_toggle;
      flips   = 0;
      b       = '0;
      for (int i = 0; i < 300; i++) begin
         b = 8'($urandom);
         send_byte(b, 1'b0, 8'h00);
         chk("burst_idx", 32'(bus.rx_idx), (i < IDX_MAX) ? i : IDX_MAX);
         if (bus.rx_toggle !== tg_prev) flips++;
         tg_prev = bus.rx_toggle;
      end
      chk("burst_flips", flips, 300);
      chk("burst_last",  32'(bus.rx_byte), 32'(b));
      chk("burst_hold",  32'(bus.rx_idx), 'hFF);

      // Runt counter saturation
      for (int k = 0; k < 260; k++) begin
         send(1'b0, 1'b1, 1'($urandom), 8'h00);
         send(1'b0, 1'b0, 1'($urandom), 8'h00);
      end
      chk("runt_sat", 32'(bus.runt_cnt), 'hFF);
      chk("runt_sat_err", 32'(bus.frame_err), 'h1);

      // Randomised frames, partial bytes, idle clocks and resets
      for (int f = 0; f < 150; f++) begin
         if ($urandom_range(0, 15) == 0) send(1'b1, 1'b0, 1'($urandom), 8'($urandom));
         send_byte(8'($urandom), 1'b1, 8'($urandom));
         nb = $urandom_range(0, 4);
         for (int j = 0; j < nb; j++) send_byte(8'($urandom), 1'b0, 8'($urandom));
         case ($urandom_range(0, 3))
            0: repeat ($urandom_range(1, 7)) send(1'b0, 1'b0, 1'($urandom), 8'($urandom));
            1: repeat ($urandom_range(1, 5)) send(1'b0, 1'b0, 1'($urandom), 8'($urandom));
            default: ;
         endcase
      end

      send(1'b1, 1'b0, 1'b0, 8'h00);
      chk_zero("final");
      send(1'b0, 1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_frame_engine.md
# spi_frame_engine

SPI-clock-domain framing stage between the SPI pins and the 40 MHz register decoder. It turns the Pico's MOSI bit stream into address and data bytes, and streams multi-byte bursts. It serialises readback bytes onto MISO and counts truncated ("runt") frames. Each completed byte is announced with a level toggle, so the 40 MHz side can resynchronise it.

## Interface

Parameters:
- `BYTE_CNT_W`, default 8: width of the per-frame byte index; saturates at its maximum.
- `RUNT_CNT_W`, default 8: width of the runt-frame counter; saturates at its maximum.

Ports:
- `spi_clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spi_start`  in  1  high on the first rising `spi_clk` edge of a chip-select assertion (output of the async-set framing flop).
- `spi_mosi`  in  1  controller data, sampled on rising `spi_clk`.
- `tx_data`  in  8  readback byte for the current address; sampled at each byte boundary.
- `addr_peek`  out  8  combinational `{sr[6:0], spi_mosi}`; equals the address byte on the edge where `bit_cnt==7` of byte 0.
- `addr`  out  8  registered address byte of the current frame.
- `addr_toggle`  out  1  flips when `addr` is captured.
- `rx_byte`  out  8  most recent data byte.
- `rx_idx`  out  `BYTE_CNT_W`  data-byte index within the frame, 0 = first byte after the address.
- `rx_toggle`  out  1  flips when `rx_byte` and `rx_idx` update.
- `rd_toggle`  out  1  flips each time `tx_data` is loaded while `addr[7]==1`; requests the next readback byte.
- `miso_bit`  out  1  next MISO bit; retimed downstream by a falling-edge flop.
- `runt_cnt`  out  `RUNT_CNT_W`  count of runt frames.
- `frame_err`  out  1  sticky; set by any runt frame.

## Operation

- Reset clears everything: state to IDLE, every output to 0, shift registers to 0.
- States:
  - IDLE: ignores MOSI.
  - ADDR: bits 0–7.
  - DATA: all bytes after the address; stays here while clocks continue.
- Any state, `spi_start==1`: go to ADDR. `sr <= {7'b0, spi_mosi}`, `bit_cnt <= 1`, `rx_idx` pending reset to 0.
- ADDR, `bit_cnt==7`:
  - `addr <= addr_peek`, flip `addr_toggle`, go to DATA, `bit_cnt <= 0`.
  - Load `tx_shift <= tx_data`, `miso_bit <= tx_data[7]`.
  - If `addr_peek[7]`, flip `rd_toggle`.
- DATA: shift `sr` and `tx_shift` each edge; `miso_bit <= tx_shift[6]`, then further bits in order.
- DATA, `bit_cnt==7`:
  - `rx_byte <= {sr[6:0], spi_mosi}`, flip `rx_toggle`.
  - `rx_idx` takes the current byte's index (0 for the first data byte).
  - Reload `tx_shift` from `tx_data`; flip `rd_toggle` if `addr[7]`.
- Burst: the address is held and the index increments. The index saturates at `2^BYTE_CNT_W-1`, and every byte at saturation still toggles.
- Runt frame: `spi_start` while in ADDR, or while in DATA with `bit_cnt!=0`.
  - `runt_cnt` increments, saturating.
  - `frame_err` is set.
  - The partial byte is discarded (no toggle) and the new frame starts normally.
- `spi_start` in DATA with `bit_cnt==0` is a clean frame boundary; no error.

## Timing

- The address is visible on `addr_peek` combinationally during edge 8. `addr` and `addr_toggle` are registered at edge 8.
- Downstream must present `tx_data` derived from `addr_peek` at edge 8. The first readback bit is loaded at edge 8, retimed on the following falling edge, and sampled by the controller at edge 9.
- `rx_byte` and `rx_toggle` update at edges 16, 24, 32, …
- For later bytes, `tx_data` must be stable at each byte-boundary edge. A downstream consumer has 8 `spi_clk` periods after a `rd_toggle` flip to update `tx_data`.
- Reset has priority over `spi_start`.
- Reset mid-frame: go to IDLE; remaining bits are ignored until the next `spi_start`; no error is counted.
- A toggle is never flipped twice within 8 edges, so 40 MHz double-flop plus edge-detect sampling is sufficient.

## Structure

- Shared package `rk_spi_pkg` holds:
  - State enum: IDLE, ADDR, DATA.
  - `SPI_READ_BIT = 7`.
  - Register-address constants used downstream: 0x00, 0x04, 0x05, 0x06, 0x20, 0x80–0x83, 0x88, 0x90, 0x91, 0xA0.
- One natural sub-module: `spi_shift8`, an 8-bit MSB-first shift register with parallel load and bit counter, instantiated for RX and TX.

## Test plan

- Reset mid-burst, then frame 0x06,0x12 → all outputs 0 after reset; one `addr` update and one data update, no error.
- Frame 0x05 then 0xA5 → `addr=0x05` at edge 8, `addr_toggle=1`; at edge 16 `rx_byte=0xA5`, `rx_idx=0`, `rx_toggle=1`; `rd_toggle` stays 0.
- Read frame address 0x88, `tx_data` returning 0x3C then 0xC3 → MISO bits 9–16 are 0,0,1,1,1,1,0,0 and bits 17–24 are 1,1,0,0,0,0,1,1; `rd_toggle` flips at edges 8 and 16.
- 300-byte burst to 0x06 → `rx_idx` runs 0…255 and holds at 255; `rx_toggle` flips 300 times.
- `spi_start` after 5 bits, then full frame 0x20,0x55 → `runt_cnt=1`, `frame_err=1`, partial byte not reported; then `addr=0x20`, `rx_byte=0x55`.
- 260 runt frames → `runt_cnt` saturates at 255.
